// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text overlay: mode encodings and width helper.
// Imported by overlay_frame_timer and text_overlay_scroll.
package text_overlay_pkg;

   localparam logic [1:0] MODE_STATIC       = 2'b00;
   localparam logic [1:0] MODE_BLINK        = 2'b01;
   localparam logic [1:0] MODE_SCROLL       = 2'b10;
   localparam logic [1:0] MODE_SCROLL_BLINK = 2'b11;

   localparam int COORD_W = 10;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int width_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_OFF_W = width_of(60);

endpackage

// File: rtl/overlay_frame_timer.sv
// Per-frame blink and marquee-scroll counters for the text overlay.
// Ports: clk, rst_n, frame_start, en, mode in; blink_phase, scroll_off out.
module overlay_frame_timer
   import text_overlay_pkg::*;
#(
   parameter int BMP_W        = 60,
   parameter int BLINK_FRAMES = 30,
   parameter int SCROLL_DIV   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        frame_start,
   input  logic                        en,
   input  logic [1:0]                  mode,
   output logic                        blink_phase,
   output logic [width_of(BMP_W)-1:0]  scroll_off
);

   localparam int OFF_W = width_of(BMP_W);
   localparam int BC_W  = width_of(BLINK_FRAMES);
   localparam int DC_W  = width_of(SCROLL_DIV);

   localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BMP_W - 1);
   localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);
   localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(SCROLL_DIV - 1);

   logic [BC_W-1:0] blink_cnt;
   logic [DC_W-1:0] div_cnt;
   logic            scroll_on;
   logic            div_wrap;

   assign scroll_on = (mode == MODE_SCROLL) || (mode == MODE_SCROLL_BLINK);
   assign div_wrap  = (div_cnt == DC_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
         div_cnt     <= '0;
         scroll_off  <= '0;
      end else if (en && frame_start) begin
         if (blink_cnt == BC_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end

         if (div_wrap) div_cnt <= '0;
         else          div_cnt <= div_cnt + 1'b1;

         // Leaving scroll mode snaps the text back to its home column.
         if (!scroll_on)
            scroll_off <= '0;
         else if (div_wrap)
            scroll_off <= (scroll_off == OFF_LAST) ? '0 : scroll_off + 1'b1;
      end
   end

endmodule

// File: rtl/text_overlay_scroll.sv
// Two-stage monochrome bitmap overlay with blink and marquee scroll.
// Ports: clk, rst_n, x, y, frame_start, en, mode, bitmap in; overlay_active, scroll_off out.
module text_overlay_scroll
   import text_overlay_pkg::*;
#(
   parameter int BMP_W        = 60,
   parameter int BMP_H        = 10,
   parameter int SCALE_LOG2   = 3,
   parameter int ORIGIN_X     = 11,
   parameter int ORIGIN_Y     = 38,
   parameter int BLINK_FRAMES = 30,
   parameter int SCROLL_DIV   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [COORD_W-1:0]          x,
   input  logic [COORD_W-1:0]          y,
   input  logic                        frame_start,
   input  logic                        en,
   input  logic [1:0]                  mode,
   input  logic [BMP_W*BMP_H-1:0]      bitmap,
   output logic                        overlay_active,
   output logic [width_of(BMP_W)-1:0]  scroll_off
);

   localparam int OFF_W = width_of(BMP_W);
   localparam int ROW_W = width_of(BMP_H);
   localparam int IDX_W = width_of(BMP_W * BMP_H);

   localparam logic [10:0] OX = 11'(ORIGIN_X);
   localparam logic [10:0] OY = 11'(ORIGIN_Y);

   logic blink_phase;

   overlay_frame_timer #(
      .BMP_W        (BMP_W),
      .BLINK_FRAMES (BLINK_FRAMES),
      .SCROLL_DIV   (SCROLL_DIV)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .en          (en),
      .mode        (mode),
      .blink_phase (blink_phase),
      .scroll_off  (scroll_off)
   );

   // Stage 1: cell coordinates, window test, gating.
   logic [10:0] cx, cy;
   logic        in_win, gate;
   logic        blink_on;

   assign cx = 11'(x >> SCALE_LOG2);
   assign cy = 11'(y >> SCALE_LOG2);

   // Origin tests come first so cells left/above never wrap in.
   assign in_win = (cx >= OX) && ((cx - OX) < 11'(BMP_W)) &&
                   (cy >= OY) && ((cy - OY) < 11'(BMP_H));

   assign blink_on = (mode == MODE_BLINK) || (mode == MODE_SCROLL_BLINK);
   assign gate     = en && !(blink_on && !blink_phase);

   logic [OFF_W-1:0] s1_col;
   logic [ROW_W-1:0] s1_row;
   logic             s1_win;
   logic             s1_gate;
   logic [OFF_W-1:0] s1_off;

   // scroll_off is sampled with the pixel so a pixel coinciding with
   // frame_start still sees the pre-update offset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_col  <= '0;
         s1_row  <= '0;
         s1_win  <= 1'b0;
         s1_gate <= 1'b0;
         s1_off  <= '0;
      end else begin
         s1_col  <= OFF_W'(cx - OX);
         s1_row  <= ROW_W'(cy - OY);
         s1_win  <= in_win;
         s1_gate <= gate;
         s1_off  <= scroll_off;
      end
   end

   // Stage 2: modular column add and bitmap lookup.
   logic [OFF_W:0]   sum;
   logic [OFF_W-1:0] src_col;
   logic [IDX_W-1:0] bit_idx;

   assign sum     = {1'b0, s1_col} + {1'b0, s1_off};
   assign src_col = (sum >= (OFF_W+1)'(BMP_W)) ? OFF_W'(sum - (OFF_W+1)'(BMP_W))
                                                : sum[OFF_W-1:0];
   assign bit_idx = IDX_W'(s1_row) * IDX_W'(BMP_W) + IDX_W'(src_col);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overlay_active <= 1'b0;
      else        overlay_active <= s1_win & s1_gate & bitmap[bit_idx];
   end

endmodule
